// File: rtl/uart_pkg.sv
// uart_pkg: shared UART rates, receiver state type and a constant clog2.
package uart_pkg;

   localparam int CLK_RATE  = 100_000_000;
   localparam int BAUD_RATE = 19_200;

   typedef enum logic [2:0] {IDLE, STRT, DATA, PARITY, STP} rx_st_type;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchronizer for an asynchronous level, resets to 1 (idle line).
module bit_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q, s2_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) {s2_q, s1_q} <= 2'b11;
      else     {s2_q, s1_q} <= {s1_q, d};

   assign q = s2_q;

endmodule

// File: rtl/rx_core.sv
// rx_core: UART receiver, 1 start, 8 data LSB first, odd parity, 1 stop, mid-bit sampling.
// Define UART_RX_PARITY_CHECK_EN to strobe parity_err on odd-parity mismatch.
module rx_core
   import uart_pkg::*;
#(
   parameter int CLK_RATE  = uart_pkg::CLK_RATE,
   parameter int BAUD_RATE = uart_pkg::BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int BIT_CYCLES = CLK_RATE / BAUD_RATE;
   localparam int BIT_MAX    = BIT_CYCLES - 1;
   localparam int HALF_MAX   = BIT_CYCLES / 2 - 1;
   localparam int TW_RAW     = clog2(BIT_MAX + 1);
   localparam int TW         = TW_RAW < 1 ? 1 : TW_RAW;
   localparam logic [TW-1:0] BIT_MAX_T  = TW'(BIT_MAX);
   localparam logic [TW-1:0] HALF_MAX_T = TW'(HALF_MAX);

   rx_st_type     st_q, st_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    sr_q, sr_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          rx_busy_q, rx_busy_d;
   logic          rx_prev_q;
   logic [1:0]    live_q;
   logic          armed_q, armed_d;
   logic          rx_s;
   logic          wrap;
`ifdef UART_RX_PARITY_CHECK_EN
   logic          par_q, par_d;
   logic          parity_err_q, parity_err_d;
`endif

   bit_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign wrap = tmr_q == BIT_MAX_T;

   // A start is only accepted after a genuine high has been seen since reset,
   // so a line that is already low when reset releases is ignored.
   assign armed_d = armed_q | (live_q[1] & rx_s);

   always_comb begin
      st_d        = st_q;
      tmr_d       = tmr_q + 1'b1;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif
      case (st_q)
         IDLE: begin
            tmr_d = '0;
            cnt_d = '0;
            if (armed_q && rx_prev_q && !rx_s) st_d = STRT;
         end
         STRT: if (tmr_q == HALF_MAX_T) begin
            tmr_d = '0;
            st_d  = rx_s ? IDLE : DATA;
         end
         DATA: if (wrap) begin
            tmr_d = '0;
            sr_d  = {rx_s, sr_q[7:1]};
            cnt_d = cnt_q + 3'd1;
            st_d  = cnt_q == 3'd7 ? PARITY : DATA;
         end
         PARITY: if (wrap) begin
            tmr_d = '0;
`ifdef UART_RX_PARITY_CHECK_EN
            par_d = rx_s;
`endif
            st_d  = STP;
         end
         STP: if (wrap) begin
            tmr_d       = '0;
            st_d        = IDLE;
            rx_data_d   = rx_s ? sr_q : rx_data_q;
            rx_valid_d  = rx_s;
            frame_err_d = !rx_s;
`ifdef UART_RX_PARITY_CHECK_EN
            parity_err_d = rx_s & ~(^sr_q ^ par_q);
`endif
         end
         default: st_d = IDLE;
      endcase
      rx_busy_d = st_d != IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st_q        <= IDLE;
         tmr_q       <= '0;
         cnt_q       <= '0;
         sr_q        <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         rx_busy_q   <= 1'b0;
         rx_prev_q   <= 1'b1;
         live_q      <= '0;
         armed_q     <= 1'b0;
      end else begin
         st_q        <= st_d;
         tmr_q       <= tmr_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         rx_busy_q   <= rx_busy_d;
         rx_prev_q   <= rx_s;
         live_q      <= {live_q[0], 1'b1};
         armed_q     <= armed_d;
      end

`ifdef UART_RX_PARITY_CHECK_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
      end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_rx_core.sv
// tb_rx_core: directed frames against a sample-index model of the receiver, checked every cycle.
module tb_rx_core;

   localparam int DEPTH = 8192;
`ifdef UART_RX_PARITY_CHECK_EN
   localparam int PEXP = 1;
`else
   localparam int PEXP = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, parity_err, frame_err, rx_busy;

   always #5 clk = ~clk;

   rx_core #(.CLK_RATE(1_600_000), .BAUD_RATE(100_000)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .rx_busy    (rx_busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit         rv [0:DEPTH-1] = '{default: 1'b1};
   bit         rs [0:DEPTH-1] = '{default: 1'b0};
   bit         act = 1'b0;
   int         f = 0, rel = 0, fall_n = 0;
   logic [7:0] m_data = 8'h00;
   int         checks = 0, passes = 0;
   int         nv = 0, np = 0, nf = 0, last_v = -1, last_f = -1;
   logic [7:0] got [$];

   // Model: a frame whose line first reads low at edge f has its k-th bit
   // (start = 0) sampled from the line value at edge f+8+16k; strobes show at edge f+170.
   task automatic step();
      int n;
      logic [7:0] b;
      bit ev, ep, ef, eb;
      n  = cyc;
      b  = 8'h00;
      ev = 1'b0;
      ep = 1'b0;
      ef = 1'b0;
      if (n + 1 < DEPTH) begin
         rv[n+1] = rx;
         rs[n+1] = rst;
      end
      if (rst || rs[n]) begin
         act    = 1'b0;
         m_data = 8'h00;
         rel    = n + 1;
      end else begin
         if (act && n == f + 10 && rv[f+8]) act = 1'b0;
         if (act && n == f + 170) begin
            act = 1'b0;
            for (int k = 0; k < 8; k++) b[k] = rv[f + 24 + 16 * k];
            if (rv[f+168]) begin
               ev     = 1'b1;
               m_data = b;
`ifdef UART_RX_PARITY_CHECK_EN
               ep = ~(^b ^ rv[f+152]);
`endif
            end else ef = 1'b1;
         end
      end
      eb = act && n >= f + 2;
      checks++;
      if ({rx_data, rx_valid, parity_err, frame_err, rx_busy} === {m_data, ev, ep, ef, eb})
         passes++;
      else
         $display("FAIL cycle %0d outputs: got data=%h v=%b pe=%b fe=%b busy=%b, expected data=%h v=%b pe=%b fe=%b busy=%b",
                  n, rx_data, rx_valid, parity_err, frame_err, rx_busy, m_data, ev, ep, ef, eb);
      if (rx_valid) begin
         nv++;
         last_v = n;
         got.push_back(rx_data);
      end
      if (parity_err) np++;
      if (frame_err) begin
         nf++;
         last_f = n;
      end
      if (!rst && !rs[n] && !act && n - 2 >= rel && rv[n-2] && !rv[n-1]) begin
         act = 1'b1;
         f   = n - 1;
      end
   endtask

   task automatic hold(input bit v, input int c);
      rx = v;
      repeat (c) begin
         @(negedge clk);
         step();
         @(posedge clk);
      end
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit p, input bit s);
      fall_n = cyc + 1;
      hold(1'b0, 16);
      for (int k = 0; k < 8; k++) hold(b[k], 16);
      hold(p, 16);
      hold(s, 16);
   endtask

   task automatic chk(input string nm, input int a, input int e);
      checks++;
      if (a == e) passes++;
      else $display("FAIL %s: got %0d expected %0d", nm, a, e);
   endtask

   initial begin
      hold(1'b1, 3);
      chk("reset_outputs", int'({rx_data, rx_valid, parity_err, frame_err, rx_busy}), 0);
      rst = 1'b0;
      hold(1'b1, 40);

      send(8'hA5, 1'b1, 1'b1);
      hold(1'b1, 20);
      chk("a5_latency", last_v - fall_n, 170);
      chk("a5_data", int'(rx_data), 8'hA5);
      chk("a5_count", nv, 1);
      chk("a5_errs", np + nf, 0);

      send(8'h00, 1'b0, 1'b1);
      hold(1'b1, 20);
      chk("bad_parity_data", int'(rx_data), 8'h00);
      chk("bad_parity_valid", nv, 2);
      chk("bad_parity_err", np, PEXP);

      send(8'h3C, 1'b1, 1'b0);
      chk("ferr_latency", last_f - fall_n, 170);
      chk("ferr_count", nf, 1);
      chk("ferr_no_valid", nv, 2);
      chk("ferr_keeps_data", int'(rx_data), 8'h00);
      hold(1'b0, 300);
      rst = 1'b1;
      hold(1'b0, 3);
      rst = 1'b0;
      hold(1'b0, 337);
      hold(1'b1, 40);
      chk("low_no_rearm", nv + nf, 3);

      fall_n = cyc + 1;
      hold(1'b0, 6);
      hold(1'b1, 30);
      chk("glitch_busy", int'(rx_busy), 0);
      chk("glitch_no_strobe", nv + nf + np, 3 + PEXP);

      hold(1'b0, 16);
      hold(1'b1, 16 * 4 + 8);
      rst = 1'b1;
      hold(1'b1, 3);
      rst = 1'b0;
      hold(1'b1, 200);
      chk("rst_no_strobe", nv, 2);
      chk("rst_data", int'(rx_data), 0);

      send(8'h81, 1'b1, 1'b1);
      hold(1'b1, 20);
      chk("after_rst_data", int'(rx_data), 8'h81);
      chk("after_rst_latency", last_v - fall_n, 170);

      send(8'h00, 1'b1, 1'b1);
      send(8'h55, 1'b1, 1'b1);
      send(8'hFF, 1'b1, 1'b1);
      hold(1'b1, 30);
      chk("b2b_count", nv, 6);
      chk("b2b_errs", np + nf, PEXP + 1);
      chk("b2b_byte0", int'(got[3]), 8'h00);
      chk("b2b_byte1", int'(got[4]), 8'h55);
      chk("b2b_byte2", int'(got[5]), 8'hFF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
